run_check_ctrl: RTL and testbench

//  Host-side sequencer for MyDesign: initiator end of dut_run/dut_busy and reader of the DUT-written output SRAM.
//  One start runs one round: launches the DUT and times it in clocks.

---
 rtl/run_check_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_run_check_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_check_ctrl.sv
// Host-side self-test sequencer: launches the DUT, times it, then compares output vs golden SRAM words.
// Latency: SRAM compare 1 clk after address issue; done one clk after FINISH. No backpressure: start is ignored outside IDLE.
// Optional first-mismatch capture ports are built when MISMATCH_LOG_EN is defined.
module run_check_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int CYCLE_WIDTH = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ctl_busy,
    output logic                   done,
    output logic                   error,
    input  logic [ADDR_WIDTH-1:0]  num_result,
    output logic                   dut_run,
    input  logic                   dut_busy,
    output logic [ADDR_WIDTH-1:0]  out_sram_read_address,
    input  logic [DATA_WIDTH-1:0]  out_sram_read_data,
    output logic [ADDR_WIDTH-1:0]  gold_sram_read_address,
    input  logic [DATA_WIDTH-1:0]  gold_sram_read_data,
    output logic [ADDR_WIDTH:0]    correct_count,
    output logic [CYCLE_WIDTH-1:0] compute_cycles
`ifdef MISMATCH_LOG_EN
    ,
    output logic                   first_mismatch_valid,
    output logic [ADDR_WIDTH-1:0]  first_mismatch_addr,
    output logic [DATA_WIDTH-1:0]  first_mismatch_got,
    output logic [DATA_WIDTH-1:0]  first_mismatch_exp
`endif
);

    localparam int TIMER_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = TIMER_WIDTH'(TIMEOUT);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = TIMER_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]    COUNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [CYCLE_WIDTH-1:0] CYC_ONE   = CYCLE_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                 state_q, state_nxt;
    logic                   run_q, run_nxt;
    logic                   done_q, done_nxt;
    logic                   error_q, error_nxt;
    logic [ADDR_WIDTH-1:0]  num_q, num_nxt;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_nxt;
    logic [ADDR_WIDTH-1:0]  cmp_addr_q, cmp_addr_nxt;
    logic                   cmp_vld_q, cmp_vld_nxt;
    logic [ADDR_WIDTH:0]    count_q, count_nxt;
    logic [CYCLE_WIDTH-1:0] cycles_q, cycles_nxt;
    logic [CYCLE_WIDTH-1:0] cycles_inc;
    logic [TIMER_WIDTH-1:0] timer_q, timer_nxt;
    logic                   word_match;

`ifdef MISMATCH_LOG_EN
    logic                   fm_vld_q, fm_vld_nxt;
    logic [ADDR_WIDTH-1:0]  fm_addr_q, fm_addr_nxt;
    logic [DATA_WIDTH-1:0]  fm_got_q, fm_got_nxt;
    logic [DATA_WIDTH-1:0]  fm_exp_q, fm_exp_nxt;
`endif

    assign word_match = (out_sram_read_data == gold_sram_read_data);
    // compute_cycles saturates rather than wrapping on a hung DUT
    assign cycles_inc = (cycles_q == {CYCLE_WIDTH{1'b1}}) ? cycles_q : cycles_q + CYC_ONE;

    always_comb begin
        state_nxt    = state_q;
        run_nxt      = run_q;
        error_nxt    = error_q;
        num_nxt      = num_q;
        addr_nxt     = addr_q;
        cmp_addr_nxt = cmp_addr_q;
        cmp_vld_nxt  = 1'b0;
        count_nxt    = count_q;
        cycles_nxt   = cycles_q;
        timer_nxt    = timer_q;
        done_nxt     = (state_q == S_FINISH);
`ifdef MISMATCH_LOG_EN
        fm_vld_nxt   = fm_vld_q;
        fm_addr_nxt  = fm_addr_q;
        fm_got_nxt   = fm_got_q;
        fm_exp_nxt   = fm_exp_q;
`endif

        // Compare stage: data returned for the address issued last cycle
        if (cmp_vld_q) begin
            if (word_match) begin
                count_nxt = count_q + COUNT_ONE;
            end
`ifdef MISMATCH_LOG_EN
            else if (!fm_vld_q) begin
                fm_vld_nxt  = 1'b1;
                fm_addr_nxt = cmp_addr_q;
                fm_got_nxt  = out_sram_read_data;
                fm_exp_nxt  = gold_sram_read_data;
            end
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_nxt    = num_result;
                    error_nxt  = 1'b0;
                    count_nxt  = '0;
                    cycles_nxt = '0;
`ifdef MISMATCH_LOG_EN
                    fm_vld_nxt  = 1'b0;
                    fm_addr_nxt = '0;
                    fm_got_nxt  = '0;
                    fm_exp_nxt  = '0;
`endif
                    state_nxt  = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!dut_busy) begin
                    run_nxt    = 1'b1;
                    cycles_nxt = '0;
                    timer_nxt  = '0;
                    state_nxt  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cycles_nxt = cycles_inc;
                if (dut_busy) begin
                    run_nxt   = 1'b0;
                    state_nxt = S_WAIT_DONE;
                end else if (timer_q == TIMER_MAX) begin
                    run_nxt   = 1'b0;
                    error_nxt = 1'b1;
                    state_nxt = S_FINISH;
                end else begin
                    timer_nxt = timer_q + TIMER_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (dut_busy) begin
                    cycles_nxt = cycles_inc;
                end else begin
                    addr_nxt  = '0;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (num_q == '0) begin
                    state_nxt = S_FINISH;
                end else begin
                    cmp_vld_nxt  = 1'b1;
                    cmp_addr_nxt = addr_q;
                    if (addr_q == num_q - ADDR_ONE) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        addr_nxt = addr_q + ADDR_ONE;
                    end
                end
            end
            S_DRAIN: begin
                state_nxt = S_FINISH;
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            num_q      <= '0;
            addr_q     <= '0;
            cmp_addr_q <= '0;
            cmp_vld_q  <= 1'b0;
            count_q    <= '0;
            cycles_q   <= '0;
            timer_q    <= '0;
`ifdef MISMATCH_LOG_EN
            fm_vld_q   <= 1'b0;
            fm_addr_q  <= '0;
            fm_got_q   <= '0;
            fm_exp_q   <= '0;
`endif
        end else begin
            state_q    <= state_nxt;
            run_q      <= run_nxt;
            done_q     <= done_nxt;
            error_q    <= error_nxt;
            num_q      <= num_nxt;
            addr_q     <= addr_nxt;
            cmp_addr_q <= cmp_addr_nxt;
            cmp_vld_q  <= cmp_vld_nxt;
            count_q    <= count_nxt;
            cycles_q   <= cycles_nxt;
            timer_q    <= timer_nxt;
`ifdef MISMATCH_LOG_EN
            fm_vld_q   <= fm_vld_nxt;
            fm_addr_q  <= fm_addr_nxt;
            fm_got_q   <= fm_got_nxt;
            fm_exp_q   <= fm_exp_nxt;
`endif
        end
    end

    assign ctl_busy               = (state_q != S_IDLE);
    assign done                   = done_q;
    assign error                  = error_q;
    assign dut_run                = run_q;
    assign out_sram_read_address  = addr_q;
    assign gold_sram_read_address = addr_q;
    assign correct_count          = count_q;
    assign compute_cycles         = cycles_q;
`ifdef MISMATCH_LOG_EN
    assign first_mismatch_valid   = fm_vld_q;
    assign first_mismatch_addr    = fm_addr_q;
    assign first_mismatch_got     = fm_got_q;
    assign first_mismatch_exp     = fm_exp_q;
`endif

endmodule

// File: tb/tb_run_check_ctrl.sv
// Directed bench for run_check_ctrl: busy-counting DUT model plus output/golden SRAM models.
module tb_run_check_ctrl;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int CW = 32;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ctl_busy;
    logic          done;
    logic          error;
    logic [AW-1:0] num_result;
    logic          dut_run;
    logic          dut_busy;
    logic [AW-1:0] out_sram_read_address;
    logic [DW-1:0] out_sram_read_data;
    logic [AW-1:0] gold_sram_read_address;
    logic [DW-1:0] gold_sram_read_data;
    logic [AW:0]   correct_count;
    logic [CW-1:0] compute_cycles;
`ifdef MISMATCH_LOG_EN
    logic          first_mismatch_valid;
    logic [AW-1:0] first_mismatch_addr;
    logic [DW-1:0] first_mismatch_got;
    logic [DW-1:0] first_mismatch_exp;
`endif

    logic [DW-1:0] out_mem  [0:(1<<AW)-1];
    logic [DW-1:0] gold_mem [0:(1<<AW)-1];

    int busy_cnt = 0;
    int busy_len = 50;
    logic never_busy = 1'b0;
    logic force_busy = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int got_done, done_cnt, run_cnt, seen_run, found;

    always #5 clk = ~clk;

    run_check_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CYCLE_WIDTH(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ctl_busy(ctl_busy),
        .done(done),
        .error(error),
        .num_result(num_result),
        .dut_run(dut_run),
        .dut_busy(dut_busy),
        .out_sram_read_address(out_sram_read_address),
        .out_sram_read_data(out_sram_read_data),
        .gold_sram_read_address(gold_sram_read_address),
        .gold_sram_read_data(gold_sram_read_data),
        .correct_count(correct_count),
        .compute_cycles(compute_cycles)
`ifdef MISMATCH_LOG_EN
        ,
        .first_mismatch_valid(first_mismatch_valid),
        .first_mismatch_addr(first_mismatch_addr),
        .first_mismatch_got(first_mismatch_got),
        .first_mismatch_exp(first_mismatch_exp)
`endif
    );

    // DUT model: a run request seen while idle makes it busy for busy_len clocks
    always @(posedge clk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (dut_run && !never_busy) busy_cnt <= busy_len;
    end
    assign dut_busy = (busy_cnt != 0) || force_busy;

    always @(posedge clk) begin
        out_sram_read_data  <= out_mem[out_sram_read_address];
        gold_sram_read_data <= gold_mem[gold_sram_read_address];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] n);
        @(negedge clk);
        num_result = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        got_done = 0;
        done_cnt = 0;
        run_cnt  = 0;
        for (int k = 0; k < budget && got_done == 0; k++) begin
            @(negedge clk);
            if (dut_run) run_cnt++;
            if (done) begin
                got_done = 1;
                done_cnt++;
            end
        end
        @(negedge clk);
        if (done) done_cnt++;
        check("done_seen", 64'(got_done), 64'd1);
        check("done_once", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            gold_mem[i] = 16'((i * 40503) ^ 23130);
            out_mem[i]  = gold_mem[i];
        end
        reset = 1'b1;
        start = 1'b0;
        num_result = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl_busy", 64'(ctl_busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_dut_run", 64'(dut_run), 64'd0);
        check("rst_out_addr", 64'(out_sram_read_address), 64'd0);
        check("rst_gold_addr", 64'(gold_sram_read_address), 64'd0);
        check("rst_count", 64'(correct_count), 64'd0);
        check("rst_cycles", 64'(compute_cycles), 64'd0);
        reset = 1'b0;

        // Clean round: every word matches
        do_start(12'd96);
        wait_done(400);
        check("a_count", 64'(correct_count), 64'd96);
        check("a_cycles", 64'(compute_cycles), 64'd51);
        check("a_run_cycles", 64'(run_cnt), 64'd2);
        check("a_error", 64'(error), 64'd0);
        check("a_ctl_busy", 64'(ctl_busy), 64'd0);
        check("a_last_addr", 64'(out_sram_read_address), 64'h05f);
`ifdef MISMATCH_LOG_EN
        check("a_fm_valid", 64'(first_mismatch_valid), 64'd0);
`endif

        // One corrupted word at the last address of a 96-word round
        out_mem[12'h05f] = gold_mem[12'h05f] ^ 16'h0001;
        do_start(12'd96);
        wait_done(400);
        check("b_count", 64'(correct_count), 64'd95);
        check("b_cycles", 64'(compute_cycles), 64'd51);
        check("b_error", 64'(error), 64'd0);
`ifdef MISMATCH_LOG_EN
        check("b_fm_valid", 64'(first_mismatch_valid), 64'd1);
        check("b_fm_addr", 64'(first_mismatch_addr), 64'h05f);
        check("b_fm_got", 64'(first_mismatch_got), 64'(gold_mem[12'h05f] ^ 16'h0001));
        check("b_fm_exp", 64'(first_mismatch_exp), 64'(gold_mem[12'h05f]));
`endif

        // 144 words: ends at 0x08f, corrupted word still counted as a miss
        do_start(12'd144);
        wait_done(500);
        check("c_count", 64'(correct_count), 64'd143);
        check("c_out_addr", 64'(out_sram_read_address), 64'h08f);
        check("c_gold_addr", 64'(gold_sram_read_address), 64'h08f);

        // N = 0: no reads, address stays 0
        do_start(12'd0);
        wait_done(400);
        check("d_count", 64'(correct_count), 64'd0);
        check("d_addr", 64'(out_sram_read_address), 64'd0);
        check("d_cycles", 64'(compute_cycles), 64'd51);

        // DUT never goes busy: timeout after TO+1 clocks of dut_run
        never_busy = 1'b1;
        do_start(12'd96);
        wait_done(TO + 200);
        check("e_run_cycles", 64'(run_cnt), 64'(TO + 1));
        check("e_error", 64'(error), 64'd1);
        check("e_dut_run", 64'(dut_run), 64'd0);
        check("e_count", 64'(correct_count), 64'd0);
        never_busy = 1'b0;

        // DUT busy at start; mid-round start pulses and num_result changes ignored
        force_busy = 1'b1;
        do_start(12'd96);
        num_result = 12'd5;
        seen_run = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (dut_run) seen_run++;
            start = (k == 2);
        end
        check("f_run_held_low", 64'(seen_run), 64'd0);
        check("f_ctl_busy", 64'(ctl_busy), 64'd1);
        check("f_error_cleared", 64'(error), 64'd0);
        force_busy = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        check("f_count", 64'(correct_count), 64'd95);
        check("f_cycles", 64'(compute_cycles), 64'd51);
        check("f_error", 64'(error), 64'd0);

        // Reset asserted during READ
        do_start(12'd96);
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            if (out_sram_read_address == 12'd10 && ctl_busy) found = 1;
        end
        check("g_reached_read", 64'(found), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("g_ctl_busy", 64'(ctl_busy), 64'd0);
        check("g_done", 64'(done), 64'd0);
        check("g_dut_run", 64'(dut_run), 64'd0);
        check("g_addr", 64'(out_sram_read_address), 64'd0);
        check("g_count", 64'(correct_count), 64'd0);
        check("g_cycles", 64'(compute_cycles), 64'd0);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("g_no_done", 64'(done_cnt), 64'd0);
        do_start(12'd96);
        wait_done(400);
        check("h_count", 64'(correct_count), 64'd95);
        check("h_cycles", 64'(compute_cycles), 64'd51);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
